// File: rtl/vedic_mul32_sequencer.sv
// rtl/vedic_mul32_sequencer.sv - 32x32 unsigned multiplier sequenced over one 16-bit vedic core
// Optional build macro: APPROX_SKIP_LL_EN (drops the aL*bL partial product, 3-cycle latency)

// 2x2 vedic base cell
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;
  assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ c1;
  assign p[3] = (a[1] & b[1]) & c1;
endmodule

// 4x4 built from four 2x2 cells (vertical and crosswise terms)
module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;
  vedic_2x2 u0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic_2x2 u1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic_2x2 u2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic_2x2 u3 (.a(a[3:2]), .b(b[3:2]), .p(q3));
  assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

// 8x8 built from four 4x4 blocks
module vedic_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;
  vedic_4x4 u0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic_4x4 u1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic_4x4 u2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic_4x4 u3 (.a(a[7:4]), .b(b[7:4]), .p(q3));
  assign p = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
endmodule

// 16x16 core shared by every partial product of the sequencer
module sixteen_bit_vedic_multiplier (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [15:0] q0, q1, q2, q3;
  vedic_8x8 u0 (.a(a[7:0]),  .b(b[7:0]),  .p(q0));
  vedic_8x8 u1 (.a(a[15:8]), .b(b[7:0]),  .p(q1));
  vedic_8x8 u2 (.a(a[7:0]),  .b(b[15:8]), .p(q2));
  vedic_8x8 u3 (.a(a[15:8]), .b(b[15:8]), .p(q3));
  assign p = {16'b0, q0} + {8'b0, q1, 8'b0} + {8'b0, q2, 8'b0} + {q3, 16'b0};
endmodule

module vedic_mul32_sequencer #(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, LL, LH, HL, HH, DONE} state_t;

  state_t      state;
  logic [31:0] a, b;
  logic [63:0] acc;
  logic [15:0] ma, mb;
  logic [31:0] p;
  logic        accept;
  logic        zero_op;

  assign accept  = in_valid & in_ready;
  assign zero_op = ZERO_BYPASS && ((in1 == 32'd0) || (in2 == 32'd0));

  // Route the operand halves for the current partial product into the shared core
  always_comb begin
    ma = 16'd0;
    mb = 16'd0;
    case (state)
      LL: begin ma = a[15:0];  mb = b[15:0];  end
      LH: begin ma = a[15:0];  mb = b[31:16]; end
      HL: begin ma = a[31:16]; mb = b[15:0];  end
      HH: begin ma = a[31:16]; mb = b[31:16]; end
      default: begin ma = 16'd0; mb = 16'd0; end
    endcase
  end

  sixteen_bit_vedic_multiplier u_core (.a(ma), .b(mb), .p(p));

  // Sequencer FSM; all handshake outputs and the result are registered here.
  // A zero operand jumps straight to HH with acc cleared: aH*bH is necessarily
  // zero there, so HH finishes the bypass in one cycle with a zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= 64'd0;
      busy      <= 1'b0;
      a         <= 32'd0;
      b         <= 32'd0;
      acc       <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a        <= in1;
            b        <= in2;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (zero_op) begin
              acc   <= 64'd0;
              state <= HH;
            end else begin
`ifdef APPROX_SKIP_LL_EN
              state <= LH;
`else
              state <= LL;
`endif
            end
          end
        end
        LL: begin
          acc   <= {32'd0, p};
          state <= LH;
        end
        LH: begin
`ifdef APPROX_SKIP_LL_EN
          acc   <= {16'd0, p, 16'd0};
`else
          acc   <= acc + {16'd0, p, 16'd0};
`endif
          state <= HL;
        end
        HL: begin
          acc   <= acc + {16'd0, p, 16'd0};
          state <= HH;
        end
        HH: begin
          acc       <= acc + {p, 32'd0};
          out       <= acc + {p, 32'd0};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_mul32_sequencer.sv
// tb/tb_vedic_mul32_sequencer.sv - directed self-checking bench for vedic_mul32_sequencer
module tb_vedic_mul32_sequencer;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        busy;

  int compared;
  int mismatched;

`ifdef APPROX_SKIP_LL_EN
  localparam int          LAT       = 3;
  localparam logic [63:0] EXP_SMALL = 64'h0;
  localparam logic [63:0] EXP_FULL  = 64'hFFFF_FFFD_0002_0000;
  localparam logic [63:0] EXP_MIX   = 64'h0000_000A_001D_0000;
`else
  localparam int          LAT       = 4;
  localparam logic [63:0] EXP_SMALL = 64'h0000_0000_0009_26F2;
  localparam logic [63:0] EXP_FULL  = 64'hFFFF_FFFE_0000_0001;
  localparam logic [63:0] EXP_MIX   = 64'h0000_000A_001D_0015;
`endif

  vedic_mul32_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp_out, input int exp_lat);
    chk({tag, ".in_ready_pre"}, {63'd0, in_ready}, 64'd1);
    in1 = x;
    in2 = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
    chk({tag, ".busy"}, {63'd0, busy}, 64'd1);
    wait_valid(tag, exp_lat);
    chk({tag, ".out"}, out, exp_out);
    chk({tag, ".in_ready_done"}, {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".out_valid_post"}, {63'd0, out_valid}, 64'd0);
    chk({tag, ".in_ready_post"}, {63'd0, in_ready}, 64'd1);
    chk({tag, ".out_hold"}, out, exp_out);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in1        = 32'd0;
    in2        = 32'd0;
    out_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset.in_ready",  {63'd0, in_ready},  64'd1);
    chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset.out",       out,                64'd0);
    chk("reset.busy",      {63'd0, busy},      64'd0);

    run_op("small", 32'd782, 32'd767, EXP_SMALL, LAT);
    run_op("full",  32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_FULL, LAT);
    run_op("cross", 32'h0001_0000, 32'h0000_0003, 64'h0000_0000_0003_0000, LAT);
    run_op("hihi",  32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, LAT);
    run_op("mix",   32'h0002_0003, 32'h0005_0007, EXP_MIX, LAT);

    // Backpressure: result held while the consumer stalls, new operands ignored
    in1 = 32'h0001_0000;
    in2 = 32'h0000_0003;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid("bp", LAT);
    chk("bp.out", out, 64'h0000_0000_0003_0000);
    in1 = 32'd782;
    in2 = 32'd767;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp.hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp.hold_out",   out,                64'h0000_0000_0003_0000);
      chk("bp.hold_ready", {63'd0, in_ready},  64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp.idle_valid", {63'd0, out_valid}, 64'd0);
    chk("bp.idle_ready", {63'd0, in_ready},  64'd1);
    chk("bp.idle_busy",  {63'd0, busy},      64'd0);
    step();
    in_valid = 1'b0;
    chk("bp.accepted_busy", {63'd0, busy}, 64'd1);
    wait_valid("bp2", LAT);
    chk("bp2.out", out, EXP_SMALL);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Zero bypass after a nonzero result so out=0 is a real change
    run_op("mix2", 32'h0002_0003, 32'h0005_0007, EXP_MIX, LAT);
    run_op("zero", 32'd0, 32'h0000_1234, 64'd0, 1);
    run_op("mix3", 32'h0002_0003, 32'h0005_0007, EXP_MIX, LAT);

    // Reset asserted while the sequencer sits in HL
    in1 = 32'hFFFF_FFFF;
    in2 = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef APPROX_SKIP_LL_EN
    step();
`else
    step();
    step();
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mid.out",       out,                64'd0);
    chk("rst_mid.in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_mid.busy",      {63'd0, busy},      64'd0);
    step();
    chk("rst_mid.no_valid",  {63'd0, out_valid}, 64'd0);

    run_op("recover", 32'd782, 32'd767, EXP_SMALL, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
